// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO for producer/consumer buffering.
//
// Parameters
//   DATA_W   word width in bits
//   ADDR_W   log2 of depth (DEPTH = 2**ADDR_W)
//   AF_LEVEL almost_full threshold  (count >= AF_LEVEL)
//   AE_LEVEL almost_empty threshold (count <= AE_LEVEL)
//   FWFT     1: head word shown on r_data while not empty
//            0: r_data registered, loaded the cycle after an accepted read
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   w_data, wr          write word and write request
//   rd                  read request
//   flush               synchronous clear of contents and pointers
//   clr_err             synchronous clear of sticky error flags
//   r_data, r_valid     read word and its qualifier
//   full, empty         count == DEPTH / count == 0
//   almost_full/empty   programmable occupancy thresholds
//   count               occupancy 0..DEPTH
//   overflow/underflow  sticky rejected-write / rejected-read flags
module fifo_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] w_data,
  input  logic              wr,
  input  logic              rd,
  input  logic              flush,
  input  logic              clr_err,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int CW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_afull;
  logic              r_aempty;
  logic              r_ovf;
  logic              r_udf;

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [ADDR_W:0]   w_count_nxt;

  // Acceptance uses the registered flags only; a write into a full FIFO is
  // legal when a read frees a slot in the same cycle.
  assign w_rd_acc = rd & ~r_empty;
  assign w_wr_acc = wr & (~r_full | w_rd_acc);

  always_comb begin
    w_count_nxt = r_count;
    if (flush)
      w_count_nxt = '0;
    else if (w_wr_acc & ~w_rd_acc)
      w_count_nxt = r_count + 1'b1;
    else if (w_rd_acc & ~w_wr_acc)
      w_count_nxt = r_count - 1'b1;
  end

  // Storage is never reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_acc & ~flush)
      r_mem[r_wr_ptr] <= w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count  <= w_count_nxt;
      // Flags come from the next-state count so they line up with count.
      r_full   <= (w_count_nxt == DEPTH_C);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= AF_C);
      r_aempty <= (w_count_nxt <= AE_C);
      // A new error event wins over clr_err; requests during flush are ignored.
      r_ovf    <= (r_ovf & ~clr_err) | (~flush & wr & ~w_wr_acc);
      r_udf    <= (r_udf & ~clr_err) | (~flush & rd & ~w_rd_acc);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is forced to zero while empty so r_data is 0 out of reset.
      assign r_data  = r_empty ? '0 : r_mem[r_rd_ptr];
      assign r_valid = ~r_empty;
    end else begin : g_reg
      logic [DATA_W-1:0] r_rd_data;
      logic              r_rd_valid;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else if (flush) begin
          r_rd_valid <= 1'b0;
        end else if (w_rd_acc) begin
          r_rd_data  <= r_mem[r_rd_ptr];
          r_rd_valid <= 1'b1;
        end else begin
          r_rd_valid <= 1'b0;
        end
      end

      assign r_data  = r_rd_data;
      assign r_valid = r_rd_valid;
    end
  endgenerate

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] w_data = '0;
  logic          wr = 1'b0, rd = 1'b0, flush = 1'b0, clr_err = 1'b0;

  // FWFT=1 instance (suffix 1) and registered-read instance (suffix 0)
  logic [DW-1:0] rdata1, rdata0;
  logic          rvalid1, rvalid0;
  logic          full1, empty1, af1, ae1, ovf1, udf1;
  logic          full0, empty0, af0, ae0, ovf0, udf0;
  logic [AW:0]   count1, count0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain queue plus error bits and the registered read port.
  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0, m_udf = 1'b0;
  logic          m_rvalid0 = 1'b0;
  logic [DW-1:0] m_rdata0 = '0;

  fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_dut1 (
    .clk(clk), .reset(reset), .w_data(w_data), .wr(wr), .rd(rd), .flush(flush),
    .clr_err(clr_err), .r_data(rdata1), .r_valid(rvalid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .w_data(w_data), .wr(wr), .rd(rd), .flush(flush),
    .clr_err(clr_err), .r_data(rdata0), .r_valid(rvalid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(udf0)
  );

  always #5 clk = ~clk;

  wire [9:0] st1 = {full1, empty1, af1, ae1, count1, ovf1, udf1};
  wire [9:0] st0 = {full0, empty0, af0, ae0, count0, ovf0, udf0};

  function automatic logic [9:0] exp_status();
    int n;
    n = q.size();
    return {(n == DEPTH), (n == 0), (n >= 6), (n <= 2), 4'(n), m_ovf, m_udf};
  endfunction

  function automatic logic [DW-1:0] exp_head();
    return (q.size() > 0) ? q[0] : '0;
  endfunction

  task automatic model_step(input logic w, input logic r, input logic [DW-1:0] d,
                            input logic f, input logic c);
    logic racc, wacc;
    if (f) begin
      q.delete();
      m_rvalid0 = 1'b0;
      m_ovf = m_ovf & ~c;
      m_udf = m_udf & ~c;
    end else begin
      racc = r && (q.size() > 0);
      wacc = w && ((q.size() < DEPTH) || racc);
      if (racc) begin
        m_rdata0  = q.pop_front();
        m_rvalid0 = 1'b1;
      end else begin
        m_rvalid0 = 1'b0;
      end
      if (wacc) q.push_back(d);
      m_ovf = (m_ovf & ~c) | (w & ~wacc);
      m_udf = (m_udf & ~c) | (r & ~racc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rvalid0 = 1'b0;
    m_rdata0 = '0;
  endtask

  // Drive one clock of requests; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d,
                       input logic f, input logic c);
    wr = w; rd = r; w_data = d; flush = f; clr_err = c;
    model_step(w, r, d, f, c);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_checks++;
    if (st1 !== 10'b0101_0000_00) begin
      n_fail++; $display("FAIL reset_status1: got %b expected %b", st1, 10'b0101000000);
    end
    n_checks++;
    if (st0 !== 10'b0101_0000_00) begin
      n_fail++; $display("FAIL reset_status0: got %b expected %b", st0, 10'b0101000000);
    end
    n_checks++;
    if ({rdata1, rdata0, rvalid1, rvalid0} !== '0) begin
      n_fail++; $display("FAIL reset_rport: got %h/%h v=%b/%b expected 0", rdata1, rdata0, rvalid1, rvalid0);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0, 1'b0);
      n_checks++;
      if (count1 !== 4'(i + 1) || empty1 !== 1'b0 || af1 !== (i + 1 >= 6) || full1 !== (i == 7)) begin
        n_fail++;
        $display("FAIL fill_%0d: got count=%0d empty=%b af=%b full=%b expected count=%0d empty=0 af=%b full=%b",
                 i, count1, empty1, af1, full1, i + 1, (i + 1 >= 6), (i == 7));
      end
      n_checks++;
      if (st0 !== exp_status()) begin
        n_fail++; $display("FAIL fill_status0_%0d: got %b expected %b", i, st0, exp_status());
      end
    end
    n_checks++;
    if (rdata1 !== 8'h10) begin
      n_fail++; $display("FAIL fill_head: got %h expected 10", rdata1);
    end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    n_checks++;
    if (count1 !== 4'd8 || ovf1 !== 1'b1 || ovf0 !== 1'b1 || full1 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got count=%0d ovf=%b/%b full=%b expected 8 1/1 1", count1, ovf1, ovf0, full1);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rdata1 !== 8'h10 + 8'(i)) begin
        n_fail++; $display("FAIL drain_head_%0d: got %h expected %h", i, rdata1, 8'h10 + 8'(i));
      end
      cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
      n_checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== 8'h10 + 8'(i)) begin
        n_fail++; $display("FAIL drain_reg_%0d: got v=%b d=%h expected v=1 d=%h", i, rvalid0, rdata0, 8'h10 + 8'(i));
      end
    end
    n_checks++;
    if (empty1 !== 1'b1 || empty0 !== 1'b1 || udf1 !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got empty=%b/%b udf=%b expected 1/1 0", empty1, empty0, udf1);
    end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (ovf1 !== 1'b0 || ovf0 !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b/%b expected 0/0", ovf1, ovf0);
    end
  endtask

  task automatic test_underflow();
    cycle(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    n_checks++;
    if (count1 !== 4'd1 || udf1 !== 1'b1 || udf0 !== 1'b1 || rdata1 !== 8'h55 || rvalid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_sim: got count=%0d udf=%b/%b head=%h v0=%b expected 1 1/1 55 0",
               count1, udf1, udf0, rdata1, rvalid0);
    end
    // Read out the word while clearing the flag in the same cycle.
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b1);
    n_checks++;
    if (st1 !== exp_status() || udf1 !== 1'b0 || rdata0 !== 8'h55) begin
      n_fail++; $display("FAIL underflow_clear: got %b d0=%h expected %b d0=55", st1, rdata0, exp_status());
    end
    // clr_err together with a fresh underflow leaves the flag set.
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b1);
    n_checks++;
    if (udf1 !== 1'b1 || st0 !== exp_status()) begin
      n_fail++; $display("FAIL clr_vs_event: got udf=%b st0=%b expected udf=1 st0=%b", udf1, st0, exp_status());
    end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] h;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      h = exp_head();
      n_checks++;
      if (rdata1 !== h) begin
        n_fail++; $display("FAIL pass_head_%0d: got %h expected %h", i, rdata1, h);
      end
      cycle(1'b1, 1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
      n_checks++;
      if (st1 !== exp_status() || count1 !== 4'd8 || ovf1 !== 1'b0 || rdata0 !== h || rvalid0 !== 1'b1) begin
        n_fail++;
        $display("FAIL pass_%0d: got st=%b d0=%h v0=%b expected st=%b d0=%h v0=1",
                 i, st1, rdata0, rvalid0, exp_status(), h);
      end
    end
    // Last 8 words must be exactly the streamed sequence 0x8C..0x93.
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rdata1 !== 8'h8C + 8'(i)) begin
        n_fail++; $display("FAIL pass_tail_%0d: got %h expected %h", i, rdata1, 8'h8C + 8'(i));
      end
      cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_fwft0_latency();
    cycle(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    n_checks++;
    if (rvalid0 !== 1'b0 || rdata1 !== 8'h3C) begin
      n_fail++; $display("FAIL lat_write: got v0=%b head1=%h expected v0=0 head1=3c", rvalid0, rdata1);
    end
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    n_checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h3C) begin
      n_fail++; $display("FAIL lat_read: got v=%b d=%h expected v=1 d=3c", rvalid0, rdata0);
    end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (rvalid0 !== 1'b0 || rdata0 !== 8'h3C) begin
      n_fail++; $display("FAIL lat_after: got v=%b d=%h expected v=0 d=3c", rvalid0, rdata0);
    end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
    n_checks++;
    if (count1 !== 4'd0 || empty1 !== 1'b1 || ovf1 | udf1 | ovf0 | udf0 || rvalid0 !== 1'b0) begin
      n_fail++; $display("FAIL flush: got count=%0d empty=%b err=%b%b v0=%b expected 0 1 00 0",
                         count1, empty1, ovf1, udf1, rvalid0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0, 1'b0);
    n_checks++;
    if (st1 !== exp_status() || rdata1 !== 8'hC0) begin
      n_fail++; $display("FAIL refill: got %b head=%h expected %b head=c0", st1, rdata1, exp_status());
    end
    #1 reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (count1 !== 4'd0 || empty1 !== 1'b1 || count0 !== 4'd0 || empty0 !== 1'b1 || rdata1 !== 8'h00) begin
      n_fail++; $display("FAIL async_reset: got count=%0d/%0d empty=%b/%b head=%h expected 0/0 1/1 00",
                         count1, count0, empty1, empty0, rdata1);
    end
    @(posedge clk); #2 reset = 1'b0;
  endtask

  task automatic test_random();
    logic w, r, f, c;
    logic [DW-1:0] d;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 15) == 0);
      d = 8'($urandom);
      cycle(w, r, d, f, c);
      n_checks++;
      if (st1 !== exp_status() || st0 !== exp_status() || rdata1 !== exp_head() ||
          rvalid1 !== (q.size() > 0) || rvalid0 !== m_rvalid0 || rdata0 !== m_rdata0) begin
        n_fail++;
        $display("FAIL random_%0d: got st=%b/%b h=%h v=%b/%b d0=%h expected st=%b h=%h v=%b/%b d0=%h",
                 i, st1, st0, rdata1, rvalid1, rvalid0, rdata0,
                 exp_status(), exp_head(), (q.size() > 0), m_rvalid0, m_rdata0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_fwft0_latency();
    test_flush_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
